// File: rtl/game_timer_bcd.sv
// ============================================================================
// game_timer_bcd : MineSweeper elapsed-seconds counter, 3-digit BCD, saturating at 999.
// Optional blink output enabled by defining GAME_TIMER_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer_bcd #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_TICKS   = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1ms,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [11:0] sec_bcd,
  output logic        sec_pulse,
  output logic        running,
  output logic        maxed,
  output logic        blink
);

  localparam int MSW = $clog2(TICKS_PER_SEC);
  localparam logic [MSW-1:0] MS_LAST = MSW'(TICKS_PER_SEC - 1);
  localparam logic [MSW-1:0] MS_ONE  = MSW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_MAX   = 2'd3;

  if (TICKS_PER_SEC < 2 || BLINK_TICKS < 1) begin : g_bad_params
    $error("game_timer_bcd: TICKS_PER_SEC must be >= 2 and BLINK_TICKS >= 1");
  end

  logic [1:0]     state_q, state_d;
  logic [MSW-1:0] ms_q, ms_d;
  logic [11:0]    sec_q, sec_d;
  logic           pulse_q, pulse_d;
  logic           running_q, maxed_q;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, o;
    {h, t, o} = v;
    if (o == 4'd9) begin
      o = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {h, t, o};
  endfunction

  // clear > stop (RUN only) > start (IDLE/PAUSE only) > tick (RUN only)
  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      ms_d    = '0;
      sec_d   = '0;
    end else if (stop && state_q == S_RUN) begin
      state_d = S_PAUSE;
    end else if (start && (state_q == S_IDLE || state_q == S_PAUSE)) begin
      state_d = S_RUN;
    end else if (tick_1ms && state_q == S_RUN) begin
      if (ms_q == MS_LAST) begin
        ms_d    = '0;
        sec_d   = bcd_inc(sec_q);
        pulse_d = 1'b1;
        if (sec_d == 12'h999) begin
          state_d = S_MAX;
        end
      end else begin
        ms_d = ms_q + MS_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ms_q      <= '0;
      sec_q     <= '0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
      maxed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      pulse_q   <= pulse_d;
      running_q <= (state_d == S_RUN);
      maxed_q   <= (state_d == S_MAX);
    end
  end

`ifdef GAME_TIMER_BLINK_EN
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  // Phase restarts on every entry into a hold state; the entry-cycle tick is not counted.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (!(state_d == S_PAUSE || state_d == S_MAX) || state_d != state_q) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (tick_1ms) begin
      if (bcnt_q == B_LAST) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + B_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  assign sec_bcd   = sec_q;
  assign sec_pulse = pulse_q;
  assign running   = running_q;
  assign maxed     = maxed_q;

endmodule

`default_nettype wire

// File: tb/tb_game_timer_bcd.sv
// ============================================================================
// tb_game_timer_bcd : directed stimulus checked every cycle against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_timer_bcd;

  localparam int TPS = 4;
  localparam int BT  = 3;
`ifdef GAME_TIMER_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0, tick_1ms = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [11:0] sec_bcd;
  logic        sec_pulse, running, maxed, blink;

  game_timer_bcd #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BT)) dut (
    .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start), .stop(stop),
    .clear(clear), .sec_bcd(sec_bcd), .sec_pulse(sec_pulse), .running(running),
    .maxed(maxed), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pcnt  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: elapsed time as total credited ticks, seconds by division.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_MAX} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_total = 0;
  int      m_hold  = 0;
  bit      m_pulse = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_state <= M_IDLE; m_total <= 0; m_hold <= 0; m_pulse <= 1'b0;
    end else begin
      m_pulse <= 1'b0;
      if (clear) begin
        m_state <= M_IDLE; m_total <= 0; m_hold <= 0;
      end else if (stop && m_state == M_RUN) begin
        m_state <= M_PAUSE; m_hold <= 0;
      end else if (start && (m_state == M_IDLE || m_state == M_PAUSE)) begin
        m_state <= M_RUN;
      end else if (tick_1ms) begin
        if (m_state == M_RUN) begin
          m_total <= m_total + 1;
          if ((m_total + 1) % TPS == 0) begin
            m_pulse <= 1'b1;
            if ((m_total + 1) / TPS == 999) begin
              m_state <= M_MAX; m_hold <= 0;
            end
          end
        end else if (m_state == M_PAUSE || m_state == M_MAX) begin
          m_hold <= m_hold + 1;
        end
      end
    end
  end

  function automatic logic [11:0] to_bcd(input int s);
    return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("sec_bcd", 32'(sec_bcd), 32'(to_bcd(m_total / TPS)));
      check("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
      check("running", 32'(running), 32'(m_state == M_RUN));
      check("maxed", 32'(maxed), 32'(m_state == M_MAX));
      check("blink", 32'(blink), 32'(BLINK_ON && (m_state == M_PAUSE || m_state == M_MAX)
                                       && ((m_hold / BT) % 2 == 1)));
      check("digits_le9", 32'(sec_bcd[11:8] <= 4'd9 && sec_bcd[7:4] <= 4'd9 &&
                              sec_bcd[3:0] <= 4'd9), 32'd1);
    end
  end

  // One call = one cycle of the given inputs; pulses from the previous edge are counted.
  task automatic drive(input bit tk, input bit st, input bit sp, input bit cl, input bit rs);
    @(negedge clk);
    if (sec_pulse === 1'b1) pcnt++;
    tick_1ms = tk; start = st; stop = sp; clear = cl; reset = rs;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      drive(1, 0, 0, 0, 0);
      repeat (gap - 1) nop();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    drive(0, 0, 0, 0, 1);
    nop();
    check("reset_sec", 32'(sec_bcd), 32'h000);
    check("reset_running", 32'(running), 32'd0);
    check("reset_maxed", 32'(maxed), 32'd0);
    check("reset_blink", 32'(blink), 32'd0);

    // Three seconds of spaced ticks
    drive(0, 1, 0, 0, 0);
    pcnt = 0;
    ticks(3 * TPS, 5);
    check("run3_sec", 32'(sec_bcd), 32'h003);
    check("run3_pulses", 32'(pcnt), 32'd3);
    check("run3_running", 32'(running), 32'd1);

    // Pause ignores ticks, resume completes exact seconds
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    ticks(6, 2);
    drive(0, 0, 1, 0, 0);
    ticks(3, 2);
    drive(0, 1, 0, 0, 0);
    ticks(2, 2);
    nop();
    check("resume_sec", 32'(sec_bcd), 32'h002);
    ticks(3, 1);
    nop();
    check("no_partial_sec", 32'(sec_bcd), 32'h002);
    ticks(1, 1);
    nop();
    check("next_sec", 32'(sec_bcd), 32'h003);

    // Completing tick together with stop is dropped; partial second retained
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);
    ticks(3, 1);
    drive(1, 0, 1, 0, 0);
    nop();
    check("stop_tick_sec", 32'(sec_bcd), 32'h000);
    check("stop_tick_running", 32'(running), 32'd0);
    drive(0, 1, 0, 0, 0);
    ticks(1, 1);
    nop();
    check("retained_ms_sec", 32'(sec_bcd), 32'h001);

    // start with tick in IDLE: tick not counted
    drive(0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0);
    ticks(3, 1);
    nop();
    check("start_tick_sec", 32'(sec_bcd), 32'h000);
    ticks(1, 1);
    nop();
    check("start_tick_sec2", 32'(sec_bcd), 32'h001);

    // clear with tick wins
    ticks(3, 1);
    drive(1, 0, 0, 1, 0);
    nop();
    check("clear_tick_sec", 32'(sec_bcd), 32'h000);
    check("clear_tick_pulse", 32'(sec_pulse), 32'd0);

    // reset with clear and start high
    drive(0, 1, 0, 0, 0);
    ticks(6, 1);
    drive(0, 1, 0, 1, 1);
    nop();
    check("reset_run_sec", 32'(sec_bcd), 32'h000);
    check("reset_run_running", 32'(running), 32'd0);
    ticks(4, 1);
    nop();
    check("reset_idle_sec", 32'(sec_bcd), 32'h000);

    // Carries and saturation, ticks on consecutive cycles
    drive(0, 1, 0, 0, 0);
    ticks(10 * TPS, 1);
    nop();
    check("carry_010", 32'(sec_bcd), 32'h010);
    ticks(90 * TPS, 1);
    nop();
    check("carry_100", 32'(sec_bcd), 32'h100);
    ticks(899 * TPS, 1);
    nop();
    check("sat_sec", 32'(sec_bcd), 32'h999);
    check("sat_maxed", 32'(maxed), 32'd1);
    check("sat_running", 32'(running), 32'd0);
    drive(0, 1, 1, 0, 0);
    pcnt = 0;
    ticks(50, 1);
    nop();
    check("sat_hold_sec", 32'(sec_bcd), 32'h999);
    check("sat_no_pulse", 32'(pcnt), 32'd0);
    check("sat_still_maxed", 32'(maxed), 32'd1);
    drive(0, 0, 0, 1, 0);
    nop();
    check("sat_clear_sec", 32'(sec_bcd), 32'h000);
    check("sat_clear_maxed", 32'(maxed), 32'd0);

    // Blink phase in PAUSE
    drive(0, 1, 0, 0, 0);
    ticks(2, 1);
    drive(0, 0, 1, 0, 0);
    ticks(BT - 1, 1);
    nop();
    check("blink_before", 32'(blink), 32'd0);
    ticks(1, 1);
    nop();
    check("blink_rise", 32'(blink), 32'(BLINK_ON));
    ticks(BT - 1, 1);
    nop();
    check("blink_hold", 32'(blink), 32'(BLINK_ON));
    ticks(1, 1);
    nop();
    check("blink_fall", 32'(blink), 32'd0);
    ticks(BT, 1);
    drive(0, 1, 0, 0, 0);
    nop();
    check("blink_run", 32'(blink), 32'd0);
    nop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_timer_bcd.md
# game_timer_bcd

- Elapsed-time counter for the MineSweeper game.
- Consumes the one-cycle 1 ms tick produced by the clock-divider counter and accumulates whole seconds as three BCD digits (000–999) for the seven-segment display driver.
- Start/stop/clear come from the game-control FSM.
- Saturates at 999 and reports status flags.

## Interface

Parameters:
- TICKS_PER_SEC, 1000, number of tick_1ms pulses per counted second (≥2).
- BLINK_TICKS, 500, ticks per half-period of the blink output (≥1).

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- tick_1ms  input  1  one-cycle pulse, synchronous to clk.
- start  input  1  level-sampled start/resume request.
- stop  input  1  level-sampled pause request.
- clear  input  1  level-sampled clear-to-zero request.
- sec_bcd  output  12  {hundreds, tens, ones}, 4 bits each, BCD.
- sec_pulse  output  1  one-cycle pulse each time a second is added.
- running  output  1  high in RUN.
- maxed  output  1  high in MAX.
- blink  output  1  display-blink enable (see Configuration).

## Operation

- States:
  - IDLE: counters zero.
  - RUN: counting.
  - PAUSE: holding a nonzero or zero count.
  - MAX: saturated at 999.
- Priority per cycle: reset > clear > stop > start > tick.
- Transitions:
  - IDLE –start→ RUN.
  - RUN –stop→ PAUSE.
  - PAUSE –start→ RUN, resuming with no clear.
  - RUN –second increment that yields 999→ MAX.
  - Any state –clear→ IDLE.
  - stop is ignored in IDLE, PAUSE and MAX. start is ignored in RUN and MAX.
- Sub-second counter ms_cnt:
  - Range 0..TICKS_PER_SEC-1.
  - Width is $clog2(TICKS_PER_SEC).
  - Increments on tick_1ms only in RUN.
  - On reaching TICKS_PER_SEC-1 with a tick, it wraps to 0 and the BCD seconds increment.
- ms_cnt is retained in PAUSE, so a paused partial second is credited after resume.
- BCD increment:
  - A ones digit of 9 wraps to 0 and carries into tens.
  - A tens digit of 9 wraps to 0 and carries into hundreds.
  - No digit ever holds 10–15.
- Saturation:
  - The increment that produces 999 enters MAX.
  - In MAX, ticks are ignored and sec_bcd holds 0x999.
  - ms_cnt is forced to 0 on entry to MAX.
- Ticks arriving in IDLE or PAUSE are discarded.
- clear zeroes ms_cnt, sec_bcd and the blink counter.

## Timing

- Reset values:
  - State IDLE.
  - sec_bcd = 0x000.
  - sec_pulse, running, maxed and blink = 0.
  - ms_cnt = 0.
- All outputs are registered, with no combinational path from any input to any output.
- Latency:
  - A tick completing a second is sampled at edge N.
  - sec_bcd shows the new value and sec_pulse is high during the cycle after edge N.
  - sec_pulse stays high for exactly one cycle.
- running and maxed change at the same edge as the state change.
- start is sampled at edge N and the state becomes RUN after edge N. A tick in that same cycle is not counted, because the state was still IDLE/PAUSE.
- If stop and tick occur in the same cycle in RUN, the tick is dropped and the state becomes PAUSE.
- If clear and tick occur together, clear wins and sec_pulse stays 0.
- Reset asserted mid-count returns every register to its reset value at the next edge, regardless of other inputs.
- tick_1ms held high for multiple cycles counts once per cycle. The upstream counter guarantees single-cycle pulses.

## Configuration

- GAME_TIMER_BLINK_EN defined:
  - A blink counter counts tick_1ms pulses in PAUSE and MAX.
  - blink toggles every BLINK_TICKS ticks, starting from 0 on entry to PAUSE or MAX.
  - blink is forced to 0 in IDLE and RUN, and on clear or reset.
- GAME_TIMER_BLINK_EN undefined:
  - The blink counter is not built.
  - blink is tied to 0.
  - All other behaviour is identical.

## Test plan

- Reset, then start, then 3000 ticks spaced 5 clk apart → sec_bcd = 0x003, exactly 3 sec_pulse pulses, running = 1.
- Start, 1500 ticks, stop, 700 ticks, start, 500 ticks → sec_bcd = 0x002. The 700 ticks in PAUSE are ignored, and after the resume ms_cnt is 0 with no partial second pending.
- Start, then run to 999 seconds → the increment to 0x999 raises maxed, running = 0. 5000 further ticks leave sec_bcd at 0x999 with no sec_pulse. clear → IDLE with sec_bcd = 0x000.
- BCD carries: run from 0x009 → 0x010, and from 0x099 → 0x100. No digit ever reads above 9 on any cycle.
- Simultaneous events:
  - Completing tick together with stop in RUN → no increment, state PAUSE.
  - start together with tick in IDLE → tick not counted.
  - reset asserted during RUN with clear and start high → all outputs 0 at the next edge, state IDLE.
- With GAME_TIMER_BLINK_EN and BLINK_TICKS = 500: pause, then 1000 ticks → blink rises after tick 500 and falls after tick 1000. After start, blink = 0. Without the macro, blink = 0 throughout.
